// File: rtl/bus_arb_2m1s.sv
// Two-master / one-slave arbiter for the req/ack/resp memory bus, with an in-order
// read-ID FIFO that routes slave responses back to the issuing master.
// Optional build macro: BUS_ARB_FIXED_PRIO_EN (m0 always wins; no round-robin state).
module bus_arb_2m1s #(
  parameter int unsigned ID_FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_bi,
  input  logic [3:0]  m0_be_bi,
  input  logic [31:0] m0_wdata_bi,
  output logic        m0_ack_o,
  output logic        m0_resp_o,
  output logic [31:0] m0_rdata_bo,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_bi,
  input  logic [3:0]  m1_be_bi,
  input  logic [31:0] m1_wdata_bi,
  output logic        m1_ack_o,
  output logic        m1_resp_o,
  output logic [31:0] m1_rdata_bo,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_bo,
  output logic [3:0]  s_be_bo,
  output logic [31:0] s_wdata_bo,
  input  logic        s_ack_i,
  input  logic        s_resp_i,
  input  logic [31:0] s_rdata_bi
);

  localparam int unsigned PTR_W = (ID_FIFO_DEPTH > 1) ? $clog2(ID_FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [ID_FIFO_DEPTH-1:0] id_q, id_d;

  logic full, empty;
  logic elig0, elig1;
  logic grant0, grant1;
  logic accept, push, pop, head;

  // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
  assign full  = (count_q == CNT_W'(ID_FIFO_DEPTH));
  assign empty = (count_q == CNT_W'(0));
  assign elig0 = ~rst_i & m0_req_i & (m0_we_i | ~full);
  assign elig1 = ~rst_i & m1_req_i & (m1_we_i | ~full);

`ifdef BUS_ARB_FIXED_PRIO_EN
  assign grant0 = elig0;
  assign grant1 = elig1 & ~elig0;
`else
  logic rr_q, rr_d;

  // rr_q=1 favours m1 when both masters are eligible.
  assign grant0 = elig0 & (~elig1 | ~rr_q);
  assign grant1 = elig1 & (~elig0 | rr_q);
`endif

  assign s_req_o    = grant0 | grant1;
  assign s_we_o     = grant1 ? m1_we_i     : m0_we_i;
  assign s_addr_bo  = grant1 ? m1_addr_bi  : m0_addr_bi;
  assign s_be_bo    = grant1 ? m1_be_bi    : m0_be_bi;
  assign s_wdata_bo = grant1 ? m1_wdata_bi : m0_wdata_bi;

  assign m0_ack_o = grant0 & s_ack_i;
  assign m1_ack_o = grant1 & s_ack_i;
  assign accept   = s_req_o & s_ack_i;
  assign push     = accept & ~s_we_o;

  // Spurious responses (empty FIFO) are dropped without touching the pointers.
  assign pop  = ~rst_i & s_resp_i & ~empty;
  assign head = id_q[rd_ptr_q];

  assign m0_resp_o   = pop & ~head;
  assign m1_resp_o   = pop & head;
  assign m0_rdata_bo = s_rdata_bi;
  assign m1_rdata_bo = s_rdata_bi;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    id_d     = id_q;
    if (push) begin
      id_d[wr_ptr_q] = grant1;
      wr_ptr_d       = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      id_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      id_q     <= id_d;
    end
  end

`ifndef BUS_ARB_FIXED_PRIO_EN
  // After an accepted transfer, favour the master that was not just served.
  always_comb begin
    rr_d = rr_q;
    if (accept) begin
      rr_d = grant0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

endmodule

// File: tb/tb_bus_arb_2m1s.sv
// Self-checking bench for bus_arb_2m1s: directed vector table, streaming and
// priority sequence, then randomized traffic against a queue-based reference model.
module tb_bus_arb_2m1s;

  localparam int DEPTH = 4;
`ifdef BUS_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  localparam logic [31:0] A0 = 32'h0000_1000, A1 = 32'h0000_2000;
  localparam logic [31:0] D0 = 32'hA0A0_0000, D1 = 32'hB1B1_0000;
  localparam logic [3:0]  B0 = 4'h3,          B1 = 4'hC;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [31:0] m0_addr_bi, m1_addr_bi, m0_wdata_bi, m1_wdata_bi;
  logic [3:0]  m0_be_bi, m1_be_bi;
  logic        m0_ack_o, m1_ack_o, m0_resp_o, m1_resp_o;
  logic [31:0] m0_rdata_bo, m1_rdata_bo;
  logic        s_req_o, s_we_o;
  logic [31:0] s_addr_bo, s_wdata_bo;
  logic [3:0]  s_be_bo;
  logic        s_ack_i, s_resp_i;
  logic [31:0] s_rdata_bi;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  bus_arb_2m1s #(.ID_FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_bi(m0_addr_bi), .m0_be_bi(m0_be_bi),
    .m0_wdata_bi(m0_wdata_bi), .m0_ack_o(m0_ack_o), .m0_resp_o(m0_resp_o), .m0_rdata_bo(m0_rdata_bo),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_bi(m1_addr_bi), .m1_be_bi(m1_be_bi),
    .m1_wdata_bi(m1_wdata_bi), .m1_ack_o(m1_ack_o), .m1_resp_o(m1_resp_o), .m1_rdata_bo(m1_rdata_bo),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_bo(s_addr_bo), .s_be_bo(s_be_bo),
    .s_wdata_bo(s_wdata_bo), .s_ack_i(s_ack_i), .s_resp_i(s_resp_i), .s_rdata_bi(s_rdata_bi)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit rst, r0, w0, r1, w1, ack, resp;
    bit sreq, g, a0, a1, p0, p1;
  } vec_t;

  function automatic vec_t mk(input bit [6:0] i, input bit [5:0] e);
    vec_t v;
    {v.rst, v.r0, v.w0, v.r1, v.w1, v.ack, v.resp} = i;
    {v.sreq, v.g, v.a0, v.a1, v.p0, v.p1} = e;
    return v;
  endfunction

  task automatic set_fixed_payload();
    m0_addr_bi = A0; m1_addr_bi = A1;
    m0_wdata_bi = D0; m1_wdata_bi = D1;
    m0_be_bi = B0; m1_be_bi = B1;
  endtask

  // Directed round-robin table; each row depends on the state left by the rows before it.
  task automatic run_table();
    vec_t tbl[$];
    vec_t v;
    logic [31:0] rd;
    tbl.push_back(mk(7'b1_10_10_1_1, 6'b0_0_00_00)); // reset forces outputs low
    tbl.push_back(mk(7'b0_00_00_0_1, 6'b0_0_00_00)); // spurious response dropped
    tbl.push_back(mk(7'b0_10_10_1_0, 6'b1_0_10_00)); // both read: m0 first
    tbl.push_back(mk(7'b0_10_10_1_1, 6'b1_1_01_10)); // m1 next, m0 response
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(7'b0_10_10_0_0, 6'b1_0_00_00)); // stalled grant holds on m0
    tbl.push_back(mk(7'b0_10_10_1_0, 6'b1_0_10_00)); // ack: m0 accepted
    tbl.push_back(mk(7'b0_10_10_1_1, 6'b1_1_01_01)); // push+pop at count 2
    tbl.push_back(mk(7'b0_00_00_0_1, 6'b0_0_00_10));
    tbl.push_back(mk(7'b0_00_00_0_1, 6'b0_0_00_01));
    tbl.push_back(mk(7'b0_00_00_0_1, 6'b0_0_00_00)); // empty again
    for (int i = 0; i < DEPTH; i++)
      tbl.push_back(mk(7'b0_00_10_1_0, 6'b1_1_01_00)); // fill FIFO with m1 reads
    tbl.push_back(mk(7'b0_11_10_1_0, 6'b1_0_10_00)); // full: m0 write wins, m1 stalls
    tbl.push_back(mk(7'b0_00_10_1_1, 6'b0_0_00_01)); // pop does not free slot this cycle
    tbl.push_back(mk(7'b0_00_10_1_0, 6'b1_1_01_00)); // slot free: m1 read acked
    tbl.push_back(mk(7'b1_00_00_0_1, 6'b0_0_00_00)); // reset discards outstanding
    tbl.push_back(mk(7'b0_00_00_0_1, 6'b0_0_00_00));
    set_fixed_payload();
    for (int i = 0; i < tbl.size(); i++) begin
      v  = tbl[i];
      rd = 32'hD000_0000 + 32'(i);
      @(negedge clk_i);
      rst_i = v.rst; m0_req_i = v.r0; m0_we_i = v.w0; m1_req_i = v.r1; m1_we_i = v.w1;
      s_ack_i = v.ack; s_resp_i = v.resp; s_rdata_bi = rd;
      #2;
      chk($sformatf("row%0d_sreq", i), 32'(s_req_o), 32'(v.sreq));
      chk($sformatf("row%0d_ack0", i), 32'(m0_ack_o), 32'(v.a0));
      chk($sformatf("row%0d_ack1", i), 32'(m1_ack_o), 32'(v.a1));
      chk($sformatf("row%0d_resp0", i), 32'(m0_resp_o), 32'(v.p0));
      chk($sformatf("row%0d_resp1", i), 32'(m1_resp_o), 32'(v.p1));
      chk($sformatf("row%0d_rdata0", i), m0_rdata_bo, rd);
      chk($sformatf("row%0d_rdata1", i), m1_rdata_bo, rd);
      if (v.sreq) begin
        chk($sformatf("row%0d_swe", i), 32'(s_we_o), 32'(v.g ? v.w1 : v.w0));
        chk($sformatf("row%0d_saddr", i), s_addr_bo, v.g ? A1 : A0);
        chk($sformatf("row%0d_sbe", i), 32'(s_be_bo), 32'(v.g ? B1 : B0));
        chk($sformatf("row%0d_swdata", i), s_wdata_bo, v.g ? D1 : D0);
      end
    end
  endtask

  // Both masters stream reads; slave answers one cycle later with rdata = address.
  // Last cycle m0 drops its request and m1 must be acked in that same cycle.
  task automatic run_stream();
    int          pid[$];
    logic [31:0] paddr[$];
    int          k0, k1, exp_id;
    k0 = 0; k1 = 0;
    @(negedge clk_i);
    rst_i = 1'b1; m0_req_i = 1'b0; m1_req_i = 1'b0; s_ack_i = 1'b0; s_resp_i = 1'b0;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk_i);
      rst_i = 1'b0;
      m0_req_i = (k != 16); m1_req_i = 1'b1; m0_we_i = 1'b0; m1_we_i = 1'b0;
      m0_addr_bi = 32'h0000_0100 + 32'(4 * k0);
      m1_addr_bi = 32'h0000_0800 + 32'(4 * k1);
      s_ack_i    = 1'b1;
      s_resp_i   = (pid.size() > 0);
      s_rdata_bi = (pid.size() > 0) ? paddr[0] : 32'h0;
      #2;
      exp_id = (k == 16) ? 1 : (FIXED ? 0 : k % 2);
      chk($sformatf("stream%0d_ack0", k), 32'(m0_ack_o), 32'(exp_id == 0));
      chk($sformatf("stream%0d_ack1", k), 32'(m1_ack_o), 32'(exp_id == 1));
      if (pid.size() > 0) begin
        chk($sformatf("stream%0d_resp0", k), 32'(m0_resp_o), 32'(pid[0] == 0));
        chk($sformatf("stream%0d_resp1", k), 32'(m1_resp_o), 32'(pid[0] == 1));
        chk($sformatf("stream%0d_rdata", k), (pid[0] == 0) ? m0_rdata_bo : m1_rdata_bo, paddr[0]);
        void'(pid.pop_front());
        void'(paddr.pop_front());
      end
      pid.push_back(exp_id);
      paddr.push_back(exp_id == 0 ? m0_addr_bi : m1_addr_bi);
      if (exp_id == 0) k0++; else k1++;
    end
  endtask

  // Randomized traffic against a queue-of-IDs reference model.
  task automatic run_random(input int n);
    int   q[$];
    bit   fav1, full, e0, e1, acc, pop, we_w;
    int   win, head;
    fav1 = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk_i);
      rst_i       = (c == 0) || ($urandom_range(99) < 2);
      m0_req_i    = ($urandom_range(9) < 7);
      m1_req_i    = ($urandom_range(9) < 7);
      m0_we_i     = ($urandom_range(9) < 3);
      m1_we_i     = ($urandom_range(9) < 3);
      m0_addr_bi  = $urandom;  m1_addr_bi  = $urandom;
      m0_wdata_bi = $urandom;  m1_wdata_bi = $urandom;
      m0_be_bi    = 4'($urandom); m1_be_bi = 4'($urandom);
      s_ack_i     = ($urandom_range(3) != 0);
      s_resp_i    = ($urandom_range(9) < 4);
      s_rdata_bi  = $urandom;
      #2;
      full = (q.size() >= DEPTH);
      e0   = !rst_i && m0_req_i && (m0_we_i || !full);
      e1   = !rst_i && m1_req_i && (m1_we_i || !full);
      if (e0 && e1)  win = FIXED ? 0 : int'(fav1);
      else if (e0)   win = 0;
      else if (e1)   win = 1;
      else           win = -1;
      acc  = (win >= 0) && s_ack_i;
      pop  = !rst_i && s_resp_i && (q.size() > 0);
      head = (q.size() > 0) ? q[0] : 0;
      chk("rnd_sreq", 32'(s_req_o), 32'(win >= 0));
      chk("rnd_ack0", 32'(m0_ack_o), 32'(acc && win == 0));
      chk("rnd_ack1", 32'(m1_ack_o), 32'(acc && win == 1));
      chk("rnd_resp0", 32'(m0_resp_o), 32'(pop && head == 0));
      chk("rnd_resp1", 32'(m1_resp_o), 32'(pop && head == 1));
      chk("rnd_rdata0", m0_rdata_bo, s_rdata_bi);
      chk("rnd_rdata1", m1_rdata_bo, s_rdata_bi);
      we_w = (win == 1) ? m1_we_i : m0_we_i;
      if (win >= 0) begin
        chk("rnd_swe", 32'(s_we_o), 32'(we_w));
        chk("rnd_saddr", s_addr_bo, (win == 1) ? m1_addr_bi : m0_addr_bi);
        chk("rnd_sbe", 32'(s_be_bo), 32'((win == 1) ? m1_be_bi : m0_be_bi));
        chk("rnd_swdata", s_wdata_bo, (win == 1) ? m1_wdata_bi : m0_wdata_bi);
      end
      if (rst_i) begin
        q.delete();
        fav1 = 1'b0;
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) begin
          fav1 = (win == 0);
          if (!we_w) q.push_back(win);
        end
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; m0_req_i = 1'b0; m1_req_i = 1'b0; m0_we_i = 1'b0; m1_we_i = 1'b0;
    s_ack_i = 1'b0; s_resp_i = 1'b0; s_rdata_bi = '0;
    set_fixed_payload();
    repeat (2) @(negedge clk_i);
`ifndef BUS_ARB_FIXED_PRIO_EN
    run_table();
`endif
    run_stream();
    run_random(600);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
